// File: rtl/aes_state_buffer_if.sv
// Byte-stream handshake and permutation-control bundle for the AES state buffer.
// master = upstream/controller side, slave = the buffer itself.
interface aes_state_buffer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              sr_req;
    logic              sr_inv;
    logic              sr_done;
    logic              start_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output in_data, in_valid, sr_req, sr_inv, start_out, out_ready,
        input  in_ready, sr_done, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, sr_req, sr_inv, start_out, out_ready,
        output in_ready, sr_done, out_data, out_valid, out_last
    );
endinterface

// File: rtl/aes_state_buffer.sv
// Byte-serial 16-byte AES state register: load a block, apply ShiftRows or
// InvShiftRows in place on command, then stream the block back out.
module aes_state_buffer #(
    parameter int DATA_W = 8,
    parameter int NBYTES = 16
) (
    input logic                clk,
    input logic                rst,
    aes_state_buffer_if.slave  bus
);

    typedef enum logic [1:0] {
        LOAD,
        HOLD,
        UNLOAD
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sr_done_q, sr_done_d;
    logic [DATA_W-1:0] b_q [NBYTES];
    logic [DATA_W-1:0] b_d [NBYTES];
    logic [DATA_W-1:0] fwd [NBYTES];
    logic [DATA_W-1:0] inv [NBYTES];

    // Column-major storage: byte r+4c is row r, column c; row r rotates by r.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                fwd[r + 4*c] = b_q[r + 4*((c + r) % 4)];
                inv[r + 4*c] = b_q[r + 4*((c - r + 4) % 4)];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_done_d = 1'b0;
        b_d       = b_q;
        case (state_q)
            LOAD: begin
                if (bus.in_valid) begin
                    b_d[cnt_q] = bus.in_data;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // A permutation request wins over start_out in the same cycle.
                if (bus.sr_req) begin
                    b_d       = bus.sr_inv ? inv : fwd;
                    sr_done_d = 1'b1;
                end else if (bus.start_out) begin
                    state_d = UNLOAD;
                    cnt_d   = 4'd0;
                end
            end
            UNLOAD: begin
                if (bus.out_ready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LOAD;
            cnt_q     <= 4'd0;
            sr_done_q <= 1'b0;
            for (int i = 0; i < NBYTES; i++) begin
                b_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_done_q <= sr_done_d;
            b_q       <= b_d;
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == UNLOAD);
    assign bus.out_last  = (state_q == UNLOAD) && (cnt_q == 4'd15);
    assign bus.out_data  = b_q[cnt_q];
    assign bus.sr_done   = sr_done_q;

endmodule

// File: tb/tb_aes_state_buffer.sv
// Directed self-checking bench for aes_state_buffer: load, permute, unload,
// handshake gaps, command collisions and mid-block reset.
module tb_aes_state_buffer;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    aes_state_buffer_if #(.DATA_W(8)) bus ();

    aes_state_buffer #(.DATA_W(8), .NBYTES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Loads base..base+15; with gaps, every byte is followed by one idle cycle.
    task automatic apply_stimulus(input logic [7:0] base, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            check_output("load_in_ready", {7'd0, bus.in_ready}, 8'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = base + 8'(i);
            tick();
            if (gaps && i != 15) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                tick();
            end
        end
        bus.in_valid = 1'b0;
        check_output("hold_in_ready", {7'd0, bus.in_ready}, 8'd0);
        check_output("hold_out_valid", {7'd0, bus.out_valid}, 8'd0);
    endtask

    // Issues start_out and drains 16 bytes; with gaps, odd bytes see two stall cycles.
    task automatic unload_expect(input logic [7:0] exp [16], input bit gaps);
        bus.start_out = 1'b1;
        tick();
        bus.start_out = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (gaps && (i % 2 == 1)) begin
                bus.out_ready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    tick();
                    check_output("stall_out_data", bus.out_data, exp[i]);
                    check_output("stall_out_valid", {7'd0, bus.out_valid}, 8'd1);
                end
            end
            check_output("out_valid", {7'd0, bus.out_valid}, 8'd1);
            check_output("out_data", bus.out_data, exp[i]);
            check_output("out_last", {7'd0, bus.out_last}, (i == 15) ? 8'd1 : 8'd0);
            check_output("unload_in_ready", {7'd0, bus.in_ready}, 8'd0);
            bus.out_ready = 1'b1;
            if (i == 15) begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        check_output("after_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check_output("after_in_ready", {7'd0, bus.in_ready}, 8'd1);
    endtask

    logic [7:0] ident   [16];
    logic [7:0] shifted [16];
    logic [7:0] aa_blk  [16];

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst           = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.sr_req    = 1'b0;
        bus.sr_inv    = 1'b0;
        bus.start_out = 1'b0;
        bus.out_ready = 1'b0;
        ident   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                    8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        shifted = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                    8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
        aa_blk  = '{8'hAA, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB0, 8'hB1,
                    8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};

        tick();
        tick();
        check_output("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check_output("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check_output("rst_out_last", {7'd0, bus.out_last}, 8'd0);
        check_output("rst_sr_done", {7'd0, bus.sr_done}, 8'd0);
        check_output("rst_out_data", bus.out_data, 8'h00);
        rst = 1'b0;
        tick();

        $display("[TB] step 1: plain load/unload");
        apply_stimulus(8'h00, 1'b0);
        unload_expect(ident, 1'b0);

        $display("[TB] step 2: ShiftRows");
        apply_stimulus(8'h00, 1'b0);
        bus.sr_req = 1'b1;
        bus.sr_inv = 1'b0;
        tick();
        bus.sr_req = 1'b0;
        check_output("sr_done_pulse", {7'd0, bus.sr_done}, 8'd1);
        tick();
        check_output("sr_done_once", {7'd0, bus.sr_done}, 8'd0);
        unload_expect(shifted, 1'b0);

        $display("[TB] step 3: ShiftRows then InvShiftRows back-to-back");
        apply_stimulus(8'h00, 1'b0);
        bus.sr_req = 1'b1;
        bus.sr_inv = 1'b0;
        tick();
        check_output("sr_done_fwd", {7'd0, bus.sr_done}, 8'd1);
        bus.sr_inv = 1'b1;
        tick();
        check_output("sr_done_inv", {7'd0, bus.sr_done}, 8'd1);
        bus.sr_req = 1'b0;
        bus.sr_inv = 1'b0;
        tick();
        check_output("sr_done_idle", {7'd0, bus.sr_done}, 8'd0);
        unload_expect(ident, 1'b0);

        $display("[TB] step 4: gapped load and stalled unload");
        apply_stimulus(8'h00, 1'b1);
        unload_expect(ident, 1'b1);

        $display("[TB] step 5: sr_req with start_out, in_valid outside LOAD");
        apply_stimulus(8'h00, 1'b0);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hFF;
        bus.sr_req    = 1'b1;
        bus.start_out = 1'b1;
        tick();
        bus.sr_req    = 1'b0;
        bus.start_out = 1'b0;
        check_output("collide_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check_output("collide_in_ready", {7'd0, bus.in_ready}, 8'd0);
        check_output("collide_sr_done", {7'd0, bus.sr_done}, 8'd1);
        tick();
        check_output("collide_still_hold", {7'd0, bus.out_valid}, 8'd0);
        unload_expect(shifted, 1'b0);

        $display("[TB] step 6: reset mid-load");
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h50 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_output("midrst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check_output("midrst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check_output("midrst_sr_done", {7'd0, bus.sr_done}, 8'd0);
        check_output("midrst_out_data", bus.out_data, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        apply_stimulus(8'hAA, 1'b0);
        unload_expect(aa_blk, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
